// File: rtl/msft_dv_debug_apb_pkg.sv
// Shared types for the DV debug APB arbiter.
// State encoding, request bundle and requester count.
package msft_dv_debug_apb_pkg;

  localparam int APB_ARB_NUM_REQ = 2;
  localparam int APB_PKG_AW      = 32;
  localparam int APB_PKG_DW      = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_arb_state_e;

  typedef struct packed {
    logic [APB_PKG_AW-1:0]   addr;
    logic [APB_PKG_DW-1:0]   wdata;
    logic                    write;
    logic [APB_PKG_DW/8-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/msft_dv_debug_rr_arb2.sv
// Two-input round-robin picker.
// Holds last_grant; a tie goes to the other requester.
module msft_dv_debug_rr_arb2
  import msft_dv_debug_apb_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [APB_ARB_NUM_REQ-1:0] req,
  input  logic                       upd,
  output logic                       gnt,
  output logic                       any
);

  logic last_grant;

  // pick winner: single requester wins, tie alternates
  always_comb begin
    any = |req;
    if (req == 2'b11) gnt = ~last_grant;
    else              gnt = req[1];
  end

  // remember who won so the next tie flips
  always_ff @(posedge clk_i) begin
    if (!rstn_i)         last_grant <= 1'b1;
    else if (upd && any) last_grant <= gnt;
  end

endmodule

// File: rtl/msft_dv_debug_apb_arb.sv
// Two-requester APB master: round-robin grant,
// SETUP/ACCESS sequencing, ACCESS timeout.
module msft_dv_debug_apb_arb
  import msft_dv_debug_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        req0_i,
  input  logic [APB_ADDR_WIDTH-1:0]   req0_addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   req0_wdata_i,
  input  logic                        req0_write_i,
  input  logic [APB_DATA_WIDTH/8-1:0] req0_strb_i,
  output logic                        req0_ack_o,
  output logic [APB_DATA_WIDTH-1:0]   req0_rdata_o,
  output logic                        req0_err_o,
  input  logic                        req1_i,
  input  logic [APB_ADDR_WIDTH-1:0]   req1_addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   req1_wdata_i,
  input  logic                        req1_write_i,
  input  logic [APB_DATA_WIDTH/8-1:0] req1_strb_i,
  output logic                        req1_ack_o,
  output logic [APB_DATA_WIDTH-1:0]   req1_rdata_o,
  output logic                        req1_err_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  apb_arb_state_e              state;
  logic [CW-1:0]               cnt;
  logic                        gnt_q;
  logic                        gnt;
  logic                        any;
  logic                        tmo;
  logic [APB_ARB_NUM_REQ-1:0]  req_v;
  logic [APB_DATA_WIDTH-1:0]   rd_v;
  logic                        er_v;

  assign req_v = {req1_i, req0_i};

  msft_dv_debug_rr_arb2 u_rr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req    (req_v),
    .upd    (state == IDLE),
    .gnt    (gnt),
    .any    (any)
  );

  // completion data: timeout forces err with zero data
  always_comb begin
    tmo  = TO_EN && (cnt == CNT_LAST);
    rd_v = '0;
    er_v = 1'b1;
    if (pready_i) begin
      rd_v = pwrite_o ? '0 : prdata_i;
      er_v = pslverr_i;
    end
  end

  // transfer sequencer with registered APB and response outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt_q        <= 1'b0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      pwrite_o     <= 1'b0;
      pstrb_o      <= '0;
      req0_ack_o   <= 1'b0;
      req0_rdata_o <= '0;
      req0_err_o   <= 1'b0;
      req1_ack_o   <= 1'b0;
      req1_rdata_o <= '0;
      req1_err_o   <= 1'b0;
    end else begin
      req0_ack_o <= 1'b0;
      req1_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (any) begin
            gnt_q    <= gnt;
            psel_o   <= 1'b1;
            paddr_o  <= gnt ? req1_addr_i  : req0_addr_i;
            pwdata_o <= gnt ? req1_wdata_i : req0_wdata_i;
            pwrite_o <= gnt ? req1_write_i : req0_write_i;
            pstrb_o  <= gnt ? req1_strb_i  : req0_strb_i;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i || tmo) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            cnt       <= '0;
            state     <= DONE;
            if (gnt_q) begin
              req1_ack_o   <= 1'b1;
              req1_rdata_o <= rd_v;
              req1_err_o   <= er_v;
            end else begin
              req0_ack_o   <= 1'b1;
              req0_rdata_o <= rd_v;
              req0_err_o   <= er_v;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msft_dv_debug_apb_arb.sv
// Directed bench for msft_dv_debug_apb_arb.
// Hand-computed expectations, timeout set to 8.
module tb_msft_dv_debug_apb_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1;
  logic [31:0] a0, a1, w0, w1;
  logic        wr0, wr1;
  logic [3:0]  s0, s1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        psel, pen, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msft_dv_debug_apb_arb #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req0_i       (req0),
    .req0_addr_i  (a0),
    .req0_wdata_i (w0),
    .req0_write_i (wr0),
    .req0_strb_i  (s0),
    .req0_ack_o   (ack0),
    .req0_rdata_o (rd0),
    .req0_err_o   (err0),
    .req1_i       (req1),
    .req1_addr_i  (a1),
    .req1_wdata_i (w1),
    .req1_write_i (wr1),
    .req1_strb_i  (s1),
    .req1_ack_o   (ack1),
    .req1_rdata_o (rd1),
    .req1_err_o   (err1),
    .psel_o       (psel),
    .penable_o    (pen),
    .paddr_o      (paddr),
    .pwdata_o     (pwdata),
    .pwrite_o     (pwrite),
    .pstrb_o      (pstrb),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; w0 = '0; w1 = '0;
    wr0 = 1'b0; wr1 = 1'b0; s0 = '0; s1 = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    chk("rst_psel", 32'(psel), 0);
    chk("rst_pen",  32'(pen), 0);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_err0", 32'(err0), 0);

    // write from req0, zero wait
    rstn = 1'b1;
    req0 = 1'b1; a0 = 32'h10; w0 = 32'hA5A5_5A5A;
    wr0 = 1'b1; s0 = 4'hF;
    pready = 1'b1; prdata = 32'hFFFF_0000;
    tick();
    chk("t1_psel", 32'(psel), 1);
    chk("t1_pen0", 32'(pen), 0);
    chk("t1_paddr", paddr, 32'h10);
    chk("t1_pwdata", pwdata, 32'hA5A5_5A5A);
    chk("t1_pwrite", 32'(pwrite), 1);
    chk("t1_pstrb", 32'(pstrb), 32'hF);
    tick();
    chk("t1_pen1", 32'(pen), 1);
    chk("t1_ack0_early", 32'(ack0), 0);
    tick();
    chk("t1_ack0", 32'(ack0), 1);
    chk("t1_ack1", 32'(ack1), 0);
    chk("t1_err0", 32'(err0), 0);
    chk("t1_rd0", rd0, 0);
    chk("t1_psel_off", 32'(psel), 0);
    req0 = 1'b0; pready = 1'b0;
    tick();
    chk("t1_ack0_pulse", 32'(ack0), 0);

    // read from req1, two wait states
    req1 = 1'b1; a1 = 32'h8004; wr1 = 1'b0; s1 = 4'h0;
    tick();
    chk("t2_psel", 32'(psel), 1);
    chk("t2_paddr_s", paddr, 32'h8004);
    chk("t2_pwrite", 32'(pwrite), 0);
    tick();
    chk("t2_pen", 32'(pen), 1);
    tick();
    chk("t2_wait1_pen", 32'(pen), 1);
    chk("t2_wait1_paddr", paddr, 32'h8004);
    chk("t2_wait1_ack", 32'(ack1), 0);
    tick();
    chk("t2_wait2_paddr", paddr, 32'h8004);
    chk("t2_wait2_ack", 32'(ack1), 0);
    pready = 1'b1; prdata = 32'h1234_5678;
    tick();
    chk("t2_ack1", 32'(ack1), 1);
    chk("t2_ack0", 32'(ack0), 0);
    chk("t2_rd1", rd1, 32'h1234_5678);
    chk("t2_err1", 32'(err1), 0);
    req1 = 1'b0; pready = 1'b0; prdata = '0;
    tick();
    chk("t2_rd1_hold", rd1, 32'h1234_5678);

    // both requesting from reset: alternate 0,1,0,1
    rstn = 1'b0;
    req0 = 1'b1; a0 = 32'h100; w0 = 32'h1111_1111;
    wr0 = 1'b1; s0 = 4'h3;
    req1 = 1'b1; a1 = 32'h200; wr1 = 1'b0;
    pready = 1'b1; prdata = 32'hCAFE_0001;
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t3_ack0_k%0d", k), 32'(ack0),
          32'((k == 3) || (k == 11)));
      chk($sformatf("t3_ack1_k%0d", k), 32'(ack1),
          32'((k == 7) || (k == 15)));
      if (k % 4 == 1)
        chk($sformatf("t3_paddr_k%0d", k), paddr,
            (k % 8 == 1) ? 32'h100 : 32'h200);
      if (k == 1) chk("t3_pstrb", 32'(pstrb), 32'h3);
      if (k == 7) chk("t3_rd1", rd1, 32'hCAFE_0001);
      if (k == 15) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    pready = 1'b0;

    // timeout: 8 ACCESS cycles then err
    req0 = 1'b1; a0 = 32'h3000; wr0 = 1'b0;
    prdata = 32'hDEAD_BEEF;
    tick();
    chk("t4_psel", 32'(psel), 1);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk($sformatf("t4_pen_k%0d", k), 32'(pen), 1);
      chk($sformatf("t4_ack_k%0d", k), 32'(ack0), 0);
    end
    tick();
    chk("t4_ack0", 32'(ack0), 1);
    chk("t4_err0", 32'(err0), 1);
    chk("t4_rd0", rd0, 0);
    chk("t4_psel_off", 32'(psel), 0);
    req0 = 1'b0;
    tick();

    // slave error on req1 write
    req1 = 1'b1; a1 = 32'h2000; wr1 = 1'b1;
    w1 = 32'h0BAD_0BAD; s1 = 4'hF;
    pready = 1'b1; pslverr = 1'b1;
    tick(); tick(); tick();
    chk("t5_ack1", 32'(ack1), 1);
    chk("t5_err1", 32'(err1), 1);
    chk("t5_err0_hold", 32'(err0), 1);
    req1 = 1'b0; pslverr = 1'b0; pready = 1'b0;
    tick();

    // reset during ACCESS, then req1-only
    req0 = 1'b1; a0 = 32'h40; wr0 = 1'b0;
    tick(); tick();
    chk("t6_in_access", 32'(pen), 1);
    rstn = 1'b0;
    tick();
    chk("t6_psel", 32'(psel), 0);
    chk("t6_pen", 32'(pen), 0);
    chk("t6_ack0", 32'(ack0), 0);
    chk("t6_err0_rst", 32'(err0), 0);
    rstn = 1'b1; req0 = 1'b0;
    req1 = 1'b1; a1 = 32'h44; wr1 = 1'b0;
    pready = 1'b1; prdata = 32'h55AA_55AA;
    tick();
    chk("t6_psel_new", 32'(psel), 1);
    chk("t6_paddr", paddr, 32'h44);
    tick(); tick();
    chk("t6_ack1", 32'(ack1), 1);
    chk("t6_ack0_none", 32'(ack0), 0);
    chk("t6_rd1", rd1, 32'h55AA_55AA);
    req1 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msft_dv_debug_apb_arb.md
Name: msft_dv_debug_apb_arb

Overview:
- Two-requester APB master arbiter/sequencer for the DV debug APB bus.
- Accepts single-beat requests from requester 0 (DPI debug driver) and requester 1 (JTAG DMI bridge), arbitrates round-robin, and drives one APB transfer at a time (SETUP then ACCESS).
- Drives the debug APB mux upstream port and returns read data and error per requester.
- Includes an ACCESS-phase timeout so a hung subordinate cannot stall the bench.

Parameters:
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width (multiple of 8).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- req0_i / req1_i  in  1  request valid; held with its fields stable until the matching ack
- reqN_addr_i  in  APB_ADDR_WIDTH  address (N=0,1)
- reqN_wdata_i  in  APB_DATA_WIDTH  write data
- reqN_write_i  in  1  1 = write
- reqN_strb_i  in  APB_DATA_WIDTH/8  write strobes
- reqN_ack_o  out  1  one-cycle completion pulse
- reqN_rdata_o  out  APB_DATA_WIDTH  read data, valid with ack
- reqN_err_o  out  1  pslverr or timeout, valid with ack
- psel_o, penable_o  out  1  APB control
- paddr_o  out  APB_ADDR_WIDTH
- pwdata_o  out  APB_DATA_WIDTH
- pwrite_o  out  1
- pstrb_o  out  APB_DATA_WIDTH/8
- prdata_i  in  APB_DATA_WIDTH
- pready_i  in  1
- pslverr_i  in  1

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous active-low on rstn_i, sampled at the clk_i edge.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - Timeout counter 0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner. Single requester: that one. Both: the one that is not last_grant.
  - Register the winner's addr, wdata, write and strb into the APB outputs; update last_grant; go to SETUP.
  - With no request, stay in IDLE, psel_o = 0.
- SETUP: psel_o = 1, penable_o = 0; go to ACCESS after exactly one cycle.
- ACCESS:
  - psel_o = 1, penable_o = 1; the timeout counter increments each cycle.
  - On pready_i = 1: capture prdata_i (0 for writes) and pslverr_i, go to DONE.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 without pready_i: abort, rdata = 0, err = 1, go to DONE.
  - pready_i and timeout in the same cycle: pready wins (normal completion).
- DONE:
  - psel_o = 0, penable_o = 0.
  - Granted reqN_ack_o = 1 for exactly this cycle, with rdata and err. The other requester's ack stays 0.
  - req inputs are ignored this cycle. Next state is IDLE; counter clears.
- Latency: request sampled in IDLE → ack 3 cycles later with zero-wait pready (IDLE→SETUP→ACCESS→DONE). Each wait state adds 1 cycle. Back-to-back throughput is one transfer per 4 cycles.
- Response outputs: rdata and err hold their value until the next DONE for that requester, so they can be read after ack.
- APB output stability: paddr, pwdata, pwrite and pstrb stay constant from SETUP through ACCESS.
- Requester rules: a requester may change its fields or drop req only in or after its ack cycle. Dropping req mid-transfer does not cancel the transfer.
- Reset mid-transfer: all state returns to reset values in the next cycle, psel/penable go to 0, no ack is issued.

Decomposition:
- Shared package msft_dv_debug_apb_pkg holds:
  - the state enum apb_arb_state_e (IDLE, SETUP, ACCESS, DONE);
  - the request struct apb_req_t (addr, wdata, write, strb);
  - the constant APB_ARB_NUM_REQ = 2.
- One natural sub-module: msft_dv_debug_rr_arb2, a two-input round-robin picker with last_grant state and an update enable.

Test Plan:
- Req0 write, addr 0x0000_0010, data 0xA5A5_5A5A, strb 0xF, zero-wait pready → psel rises 1 cycle after request, penable 1 cycle later, req0_ack 3 cycles after request, req0_err = 0.
- Req1 read, addr 0x0000_8004, pready after 2 wait states, prdata 0x1234_5678 → req1_ack at request+5, req1_rdata = 0x1234_5678; paddr stable throughout.
- Req0 and req1 both asserted continuously from reset → grants alternate 0,1,0,1; each ack 4 cycles apart; no ack lost.
- pready never asserted, TIMEOUT_CYCLES = 8 → 8 ACCESS cycles, then ack with err = 1, rdata = 0, psel drops.
- pslverr_i = 1 with pready at addr 0x0000_2000 → ack with err = 1.
- rstn_i low during ACCESS → next cycle psel = penable = 0, no ack. After reset release, a req1-only request is granted normally.
